// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks the next fetch address, checks it,
// and registers the ROM word into the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI   = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        IntReq,
  input  logic        Eret_D,
  input  logic [31:0] EPC,
  input  logic        IsJump_D,
  input  logic        BranchTaken_D,
  input  logic [31:0] Target_D,
  input  logic [31:0] Instr,
  output logic [31:0] Pc,
  output logic [31:0] Instr_D,
  output logic [31:0] Pc_D,
  output logic [4:0]  ExcCode_D,
  output logic        BD_D
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic        addr_fault;
  logic [31:0] pc_next;
  logic        flush;
  logic        hold;

  // Redirect targets are loaded unchecked; a bad one faults here a cycle later.
  assign addr_fault = (Pc[1:0] != 2'b00) || (Pc < TEXT_LO) || (Pc > TEXT_HI);

  always_comb begin
    pc_next = Pc + 32'd4;
    flush   = 1'b0;
    hold    = 1'b0;
    if (IntReq) begin
      pc_next = EXC_ENTRY;
      flush   = 1'b1;
    end else if (Stall) begin
      pc_next = Pc;
      hold    = 1'b1;
    end else if (Eret_D) begin
      // eret has no delay slot, so the word fetched behind it is dropped
      pc_next = EPC;
      flush   = 1'b1;
    end else if (BranchTaken_D) begin
      pc_next = Target_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      Pc        <= PC_RESET;
      Instr_D   <= 32'd0;
      Pc_D      <= 32'd0;
      ExcCode_D <= EXC_NONE;
      BD_D      <= 1'b0;
    end else begin
      Pc <= pc_next;
      if (flush) begin
        Instr_D   <= 32'd0;
        Pc_D      <= 32'd0;
        ExcCode_D <= EXC_NONE;
        BD_D      <= 1'b0;
      end else if (!hold) begin
        Instr_D   <= addr_fault ? 32'd0 : Instr;
        Pc_D      <= Pc;
        ExcCode_D <= addr_fault ? EXC_ADEL : EXC_NONE;
        BD_D      <= IsJump_D;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: ROM model returns 32'h1000_0000 + word index from 0x3000.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        IntReq;
  logic        Eret_D;
  logic [31:0] EPC;
  logic        IsJump_D;
  logic        BranchTaken_D;
  logic [31:0] Target_D;
  logic [31:0] Instr;
  logic [31:0] Pc;
  logic [31:0] Instr_D;
  logic [31:0] Pc_D;
  logic [4:0]  ExcCode_D;
  logic        BD_D;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb Instr = 32'h1000_0000 + ((Pc - 32'h0000_3000) >> 2);

  fetch_stage dut (
    .clk(clk), .reset(reset), .Stall(Stall), .IntReq(IntReq), .Eret_D(Eret_D),
    .EPC(EPC), .IsJump_D(IsJump_D), .BranchTaken_D(BranchTaken_D),
    .Target_D(Target_D), .Instr(Instr), .Pc(Pc), .Instr_D(Instr_D),
    .Pc_D(Pc_D), .ExcCode_D(ExcCode_D), .BD_D(BD_D)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic [31:0] e_pcd, input logic [4:0] e_exc, input logic e_bd);
    chk({tag, ".Pc"},        Pc,                e_pc);
    chk({tag, ".Instr_D"},   Instr_D,           e_instr);
    chk({tag, ".Pc_D"},      Pc_D,              e_pcd);
    chk({tag, ".ExcCode_D"}, {27'd0, ExcCode_D}, {27'd0, e_exc});
    chk({tag, ".BD_D"},      {31'd0, BD_D},      {31'd0, e_bd});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Stall = 0; IntReq = 0; Eret_D = 0; IsJump_D = 0; BranchTaken_D = 0;
  endtask

  initial begin
    reset = 0; EPC = 32'h0; Target_D = 32'h0;
    idle();
    step(); step();
    chk_all("reset", 32'h3000, 32'h0, 32'h0, 5'd0, 1'b0);

    reset = 1;
    step();
    chk_all("run1", 32'h3004, 32'h1000_0000, 32'h3000, 5'd0, 1'b0);
    step();
    chk_all("run2", 32'h3008, 32'h1000_0001, 32'h3004, 5'd0, 1'b0);

    // taken branch: delay slot kept with BD set
    IsJump_D = 1; BranchTaken_D = 1; Target_D = 32'h3100;
    step();
    chk_all("br", 32'h3100, 32'h1000_0002, 32'h3008, 5'd0, 1'b1);
    idle();
    step();
    chk_all("br_tgt", 32'h3104, 32'h1000_0040, 32'h3100, 5'd0, 1'b0);

    // not-jump redirect to 0x3010, BD stays 0
    BranchTaken_D = 1; Target_D = 32'h3010;
    step();
    chk_all("redir", 32'h3010, 32'h1000_0041, 32'h3104, 5'd0, 1'b0);
    idle();

    Stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all("stall", 32'h3010, 32'h1000_0041, 32'h3104, 5'd0, 1'b0);
    end
    Stall = 0;
    step();
    chk_all("unstall", 32'h3014, 32'h1000_0004, 32'h3010, 5'd0, 1'b0);
    step(); step(); step();
    chk_all("at3020", 32'h3020, 32'h1000_0007, 32'h301c, 5'd0, 1'b0);

    // interrupt wins over stall
    IntReq = 1; Stall = 1; IsJump_D = 1;
    step();
    chk_all("int", 32'h4180, 32'h0, 32'h0, 5'd0, 1'b0);
    idle();
    step();
    chk_all("handler", 32'h4184, 32'h1000_0460, 32'h4180, 5'd0, 1'b0);

    Eret_D = 1; EPC = 32'h3024;
    step();
    chk_all("eret", 32'h3024, 32'h0, 32'h0, 5'd0, 1'b0);
    BranchTaken_D = 1; Target_D = 32'h3100; EPC = 32'h3040;
    step();
    chk_all("eret_pri", 32'h3040, 32'h0, 32'h0, 5'd0, 1'b0);
    idle();

    // misaligned target
    BranchTaken_D = 1; Target_D = 32'h3102;
    step();
    chk_all("mis_ld", 32'h3102, 32'h1000_0010, 32'h3040, 5'd0, 1'b0);
    Target_D = 32'h7000;
    step();
    chk_all("mis_flt", 32'h7000, 32'h0, 32'h3102, 5'd4, 1'b0);
    Target_D = 32'h6ffc;
    step();
    chk_all("hi_flt", 32'h6ffc, 32'h0, 32'h7000, 5'd4, 1'b0);
    Target_D = 32'h2ffc;
    step();
    chk_all("top_ok", 32'h2ffc, 32'h1000_0fff, 32'h6ffc, 5'd0, 1'b0);
    idle();
    step();
    chk_all("lo_flt", 32'h3000, 32'h0, 32'h2ffc, 5'd4, 1'b0);
    step();
    chk_all("lo_ok", 32'h3004, 32'h1000_0000, 32'h3000, 5'd0, 1'b0);

    // reset wins over stall and redirect
    Stall = 1; BranchTaken_D = 1; Target_D = 32'h3200; IsJump_D = 1; reset = 0;
    step();
    chk_all("rst_pri", 32'h3000, 32'h0, 32'h0, 5'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
